// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit:
// op_type codes, FSM state encoding and alignment helpers.
package mem_stage_lsu_pkg;

    localparam logic [2:0] LSU_LW  = 3'd0;
    localparam logic [2:0] LSU_LH  = 3'd1;
    localparam logic [2:0] LSU_LHU = 3'd2;
    localparam logic [2:0] LSU_LB  = 3'd3;
    localparam logic [2:0] LSU_LBU = 3'd4;
    localparam logic [2:0] LSU_SW  = 3'd5;
    localparam logic [2:0] LSU_SH  = 3'd6;
    localparam logic [2:0] LSU_SB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    function automatic logic lsu_is_store(input logic [2:0] t);
        return (t == LSU_SW) || (t == LSU_SH) || (t == LSU_SB);
    endfunction

    // Unknown codes fall into the word case, matching LW handling.
    function automatic logic lsu_misaligned(input logic [2:0] t,
                                            input logic [1:0] a);
        logic m;
        case (t)
            LSU_LH, LSU_LHU, LSU_SH: m = a[0];
            LSU_LB, LSU_LBU, LSU_SB: m = 1'b0;
            default:                 m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_ext.sv
// Load-data lane select with sign/zero extension.
// Combinational: picks the byte/half lane and widens it to 32 bits.
module lsu_load_ext
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  i_op_type,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_op_type)
            LSU_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: o_data = {24'd0, w_byte};
            LSU_LH:  o_data = {{16{w_half[15]}}, w_half};
            LSU_LHU: o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator: req/ack to word memory,
// byte enables for stores, extension for loads, misalign traps.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op_type,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        r_state;
    logic              r_done;
    logic              r_adel;
    logic              r_ades;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd;
    logic [2:0]        r_type;
    logic [1:0]        r_addr_lo;

    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_store;
    logic              w_misal;
    logic [31:0]       w_ext;

    assign w_store = lsu_is_store(op_type);
    assign w_misal = lsu_misaligned(op_type, op_addr[1:0]);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = op_wdata;
        case (op_type)
            LSU_SB: begin
                w_be    = 4'b0001 << op_addr[1:0];
                w_wdata = {4{op_wdata[7:0]}};
            end
            LSU_SH: begin
                w_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_ext u_load_ext (
        .i_op_type (r_type),
        .i_addr_lo (r_addr_lo),
        .i_word    (mem_rdata),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_adel    <= 1'b0;
            r_ades    <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= 4'b0000;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_type    <= LSU_LW;
            r_addr_lo <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (w_misal) begin
                            r_adel  <= ~w_store;
                            r_ades  <= w_store;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_addr    <= {op_addr[ADDR_W-1:2], 2'b00};
                            r_be      <= w_be;
                            r_we      <= w_store;
                            r_wdata   <= w_wdata;
                            r_type    <= op_type;
                            r_addr_lo <= op_addr[1:0];
                            r_state   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rd <= w_ext;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_adel  <= 1'b0;
                    r_ades  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request comes straight from state so reset kills it at once.
    assign mem_req   = (r_state == ST_BUSY);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign done      = r_done;
    assign exc_adel  = r_adel;
    assign exc_ades  = r_ades;
    assign rd_data   = r_rd;
    assign stall     = op_valid & ~r_done;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: stores, loads, misalignment,
// wait states, back-to-back ops and reset during an access.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rd_data;
    logic        exc_adel;
    logic        exc_ades;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    int          o_done_cyc;
    int          o_req_cycles;
    logic        o_req0, o_req_seen, o_stall_bad, o_unstable, o_timeout;
    logic        o_we, o_adel, o_ades, o_done_after;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rd;

    mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_type   (op_type),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .stall     (stall),
        .done      (done),
        .rd_data   (rd_data),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Drives one op from an IDLE cycle (cycle 0) and records what
    // the memory side saw; returns one cycle after done.
    task automatic run_op(input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waits);
        int cyc;
        int reqn;
        cyc = 0;
        reqn = 0;
        op_type = t;
        op_addr = a;
        op_wdata = wd;
        op_valid = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        o_req_seen = 1'b0;
        o_stall_bad = 1'b0;
        o_unstable = 1'b0;
        o_timeout = 1'b0;
        o_done_cyc = -1;
        o_rd = 32'hx;
        o_adel = 1'bx;
        o_ades = 1'bx;
        #1;
        if (!stall) o_stall_bad = 1'b1;
        o_req0 = mem_req;
        if (mem_req) o_req_seen = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                o_done_cyc = cyc;
                o_rd = rd_data;
                o_adel = exc_adel;
                o_ades = exc_ades;
                if (stall) o_stall_bad = 1'b1;
                break;
            end
            if (cyc > 60) begin
                o_timeout = 1'b1;
                break;
            end
            if (!stall) o_stall_bad = 1'b1;
            if (mem_req) begin
                o_req_seen = 1'b1;
                if (reqn == 0) begin
                    o_be = mem_be;
                    o_addr = mem_addr;
                    o_wdata = mem_wdata;
                    o_we = mem_we;
                end else if (mem_be !== o_be || mem_addr !== o_addr ||
                             mem_wdata !== o_wdata || mem_we !== o_we) begin
                    o_unstable = 1'b1;
                end
                reqn++;
            end
            if (mem_req && reqn > waits) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
        o_req_cycles = reqn;
        op_valid = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        o_done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        op_valid = 1'b0;
        op_type = LSU_LW;
        op_addr = 32'h0;
        op_wdata = 32'h0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        #1;
        total++;
        if ({mem_req, mem_we, done, exc_adel, exc_ades, stall} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {mem_req, mem_we, done, exc_adel, exc_ades, stall});
        end
        total++;
        if ({mem_be, mem_addr, mem_wdata, rd_data} !== 100'd0) begin
            bad++;
            $display("FAIL reset_data be=%h addr=%h wd=%h rd=%h exp=0",
                     mem_be, mem_addr, mem_wdata, rd_data);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_sw;
        run_op(LSU_SW, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
        total++;
        if (o_done_cyc !== 2) begin bad++; $display("FAIL sw_latency got=%0d exp=2", o_done_cyc); end
        total++;
        if (o_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b exp=1111", o_be); end
        total++;
        if (o_wdata !== 32'h1234_5678) begin bad++; $display("FAIL sw_wdata got=%h exp=12345678", o_wdata); end
        total++;
        if (o_we !== 1'b1 || o_addr !== 32'h10) begin
            bad++; $display("FAIL sw_we_addr got=%b/%h exp=1/00000010", o_we, o_addr);
        end
        total++;
        if (o_stall_bad !== 1'b0) begin bad++; $display("FAIL sw_stall got=%b exp=0", o_stall_bad); end
        total++;
        if (o_req0 !== 1'b0) begin bad++; $display("FAIL sw_req_cycle0 got=%b exp=0", o_req0); end
        total++;
        if (o_ades !== 1'b0 || o_adel !== 1'b0) begin
            bad++; $display("FAIL sw_exc got=%b%b exp=00", o_adel, o_ades);
        end
        total++;
        if (o_done_after !== 1'b0) begin bad++; $display("FAIL sw_done_width got=%b exp=0", o_done_after); end
    endtask

    task automatic test_sub_word_store;
        run_op(LSU_SB, 32'h0000_0013, 32'h0000_00AB, 32'h0, 0);
        total++;
        if (o_addr !== 32'h10) begin bad++; $display("FAIL sb_addr got=%h exp=00000010", o_addr); end
        total++;
        if (o_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", o_be); end
        total++;
        if (o_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=abababab", o_wdata); end
        run_op(LSU_SB, 32'h0000_0011, 32'h0000_0C5A, 32'h0, 0);
        total++;
        if (o_be !== 4'b0010 || o_wdata !== 32'h5A5A_5A5A) begin
            bad++; $display("FAIL sb1_be_wdata got=%b/%h exp=0010/5a5a5a5a", o_be, o_wdata);
        end
        run_op(LSU_SH, 32'h0000_0016, 32'hCAFE_1234, 32'h0, 0);
        total++;
        if (o_addr !== 32'h14 || o_be !== 4'b1100) begin
            bad++; $display("FAIL sh_addr_be got=%h/%b exp=00000014/1100", o_addr, o_be);
        end
        total++;
        if (o_wdata !== 32'h1234_1234 || o_we !== 1'b1) begin
            bad++; $display("FAIL sh_wdata got=%h/%b exp=12341234/1", o_wdata, o_we);
        end
        run_op(LSU_SH, 32'h0000_0014, 32'h0000_BEEF, 32'h0, 0);
        total++;
        if (o_be !== 4'b0011) begin bad++; $display("FAIL sh0_be got=%b exp=0011", o_be); end
    endtask

    task automatic test_loads;
        run_op(LSU_LB, 32'h0000_0021, 32'h0, 32'h0000_8000, 0);
        total++;
        if (o_rd !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", o_rd); end
        total++;
        if (o_we !== 1'b0 || o_be !== 4'b1111 || o_addr !== 32'h20) begin
            bad++; $display("FAIL lb_req got=%b/%b/%h exp=0/1111/00000020", o_we, o_be, o_addr);
        end
        run_op(LSU_LBU, 32'h0000_0021, 32'h0, 32'h0000_8000, 0);
        total++;
        if (o_rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", o_rd); end
        run_op(LSU_LH, 32'h0000_0022, 32'h0, 32'h8001_0000, 0);
        total++;
        if (o_rd !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got=%h exp=ffff8001", o_rd); end
        run_op(LSU_LHU, 32'h0000_0022, 32'h0, 32'h8001_0000, 0);
        total++;
        if (o_rd !== 32'h0000_8001) begin bad++; $display("FAIL lhu_data got=%h exp=00008001", o_rd); end
        run_op(LSU_LB, 32'h0000_0023, 32'h0, 32'h7F00_0000, 0);
        total++;
        if (o_rd !== 32'h0000_007F || o_done_cyc !== 2) begin
            bad++; $display("FAIL lb3_data got=%h/%0d exp=0000007f/2", o_rd, o_done_cyc);
        end
        run_op(LSU_LW, 32'h0000_0030, 32'h0, 32'hA5A5_0F0F, 0);
        total++;
        if (o_rd !== 32'hA5A5_0F0F) begin bad++; $display("FAIL lw_data got=%h exp=a5a50f0f", o_rd); end
        total++;
        if (rd_data !== 32'hA5A5_0F0F) begin bad++; $display("FAIL lw_hold got=%h exp=a5a50f0f", rd_data); end
    endtask

    task automatic test_misaligned;
        run_op(LSU_LH, 32'h0000_0003, 32'h0, 32'h0, 0);
        total++;
        if (o_done_cyc !== 1) begin bad++; $display("FAIL lh_mis_latency got=%0d exp=1", o_done_cyc); end
        total++;
        if (o_adel !== 1'b1 || o_ades !== 1'b0) begin
            bad++; $display("FAIL lh_mis_exc got=%b%b exp=10", o_adel, o_ades);
        end
        total++;
        if (o_req_seen !== 1'b0) begin bad++; $display("FAIL lh_mis_req got=%b exp=0", o_req_seen); end
        run_op(LSU_SW, 32'h0000_0002, 32'h5555_5555, 32'h0, 0);
        total++;
        if (o_ades !== 1'b1 || o_adel !== 1'b0 || o_done_cyc !== 1) begin
            bad++; $display("FAIL sw_mis got=%b%b/%0d exp=01/1", o_adel, o_ades, o_done_cyc);
        end
        total++;
        if (o_req_seen !== 1'b0) begin bad++; $display("FAIL sw_mis_req got=%b exp=0", o_req_seen); end
        total++;
        if (exc_ades !== 1'b0) begin bad++; $display("FAIL sw_mis_clear got=%b exp=0", exc_ades); end
        run_op(LSU_SH, 32'h0000_0005, 32'h0, 32'h0, 0);
        total++;
        if (o_ades !== 1'b1 || o_req_seen !== 1'b0) begin
            bad++; $display("FAIL sh_mis got=%b/%b exp=1/0", o_ades, o_req_seen);
        end
    endtask

    task automatic test_wait_states;
        run_op(LSU_LW, 32'h0000_0040, 32'h0, 32'h1122_3344, 3);
        total++;
        if (o_done_cyc !== 5) begin bad++; $display("FAIL wait_latency got=%0d exp=5", o_done_cyc); end
        total++;
        if (o_req_cycles !== 4) begin bad++; $display("FAIL wait_req_cycles got=%0d exp=4", o_req_cycles); end
        total++;
        if (o_unstable !== 1'b0 || o_addr !== 32'h40) begin
            bad++; $display("FAIL wait_stable got=%b/%h exp=0/00000040", o_unstable, o_addr);
        end
        total++;
        if (o_stall_bad !== 1'b0 || o_timeout !== 1'b0) begin
            bad++; $display("FAIL wait_stall got=%b/%b exp=0/0", o_stall_bad, o_timeout);
        end
        total++;
        if (o_rd !== 32'h1122_3344) begin bad++; $display("FAIL wait_data got=%h exp=11223344", o_rd); end
    endtask

    task automatic test_back_to_back;
        run_op(LSU_LW, 32'h0000_0050, 32'h0, 32'hCAFE_F00D, 0);
        run_op(LSU_SB, 32'h0000_0052, 32'h0000_0077, 32'h0, 1);
        total++;
        if (o_done_cyc !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", o_done_cyc); end
        total++;
        if (o_be !== 4'b0100 || o_wdata !== 32'h7777_7777) begin
            bad++; $display("FAIL b2b_store got=%b/%h exp=0100/77777777", o_be, o_wdata);
        end
        total++;
        if (rd_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_rd_hold got=%h exp=cafef00d", rd_data); end
    endtask

    task automatic test_reset_busy;
        op_type = LSU_LW;
        op_addr = 32'h0000_0060;
        op_valid = 1'b1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_busy_req got=%b exp=1", mem_req); end
        reset = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_busy_drop got=%b/%b exp=0/0", mem_req, done);
        end
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL rst_busy_idle got=%b/%b exp=0/0", done, mem_req);
        end
        run_op(LSU_LW, 32'h0000_0064, 32'h0, 32'h0BAD_F00D, 0);
        total++;
        if (o_done_cyc !== 2 || o_rd !== 32'h0BAD_F00D) begin
            bad++; $display("FAIL rst_busy_next got=%0d/%h exp=2/0badf00d", o_done_cyc, o_rd);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sub_word_store();
        test_loads();
        test_misaligned();
        test_wait_states();
        test_back_to_back();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
